// File: rtl/btb_domain_tagged_if.sv
// -----------------------------------------------------------------------------
// btb_domain_tagged_if
// Bundles the lookup, update and flush signals of the domain-tagged BTB.
//   slave  modport : used by the BTB itself (requests in, results out)
//   master modport : used by the requester (pipeline front end / bench)
// Lookup : lookup_en_i, idx_i, domain_i   -> valid_o, hit_o, targ_o
// Update : update_en_i, upd_idx_i, upd_domain_i, upd_targ_i, upd_taken_i
// Flush  : flush_req_i, flush_domain_i    -> busy_o, flush_done_o
// -----------------------------------------------------------------------------
interface btb_domain_tagged_if #(
    parameter int ADDR_W = 32,
    parameter int DOM_W  = 2
);
    logic              lookup_en_i;
    logic [ADDR_W-1:0] idx_i;
    logic [DOM_W-1:0]  domain_i;
    logic              valid_o;
    logic              hit_o;
    logic [ADDR_W-1:0] targ_o;
    logic              update_en_i;
    logic [ADDR_W-1:0] upd_idx_i;
    logic [DOM_W-1:0]  upd_domain_i;
    logic [ADDR_W-1:0] upd_targ_i;
    logic              upd_taken_i;
    logic              flush_req_i;
    logic [DOM_W-1:0]  flush_domain_i;
    logic              busy_o;
    logic              flush_done_o;

    modport slave (
        input  lookup_en_i, idx_i, domain_i,
        output valid_o, hit_o, targ_o,
        input  update_en_i, upd_idx_i, upd_domain_i, upd_targ_i, upd_taken_i,
        input  flush_req_i, flush_domain_i,
        output busy_o, flush_done_o
    );

    modport master (
        output lookup_en_i, idx_i, domain_i,
        input  valid_o, hit_o, targ_o,
        output update_en_i, upd_idx_i, upd_domain_i, upd_targ_i, upd_taken_i,
        output flush_req_i, flush_domain_i,
        input  busy_o, flush_done_o
    );
endinterface

// File: rtl/btb_domain_tagged.sv
// -----------------------------------------------------------------------------
// btb_domain_tagged
// Direct-mapped branch target buffer whose entries carry the security domain
// that allocated them. A lookup only hits an entry of its own domain, and a
// sequential flush engine invalidates one domain's entries on a context switch.
//
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset (clears valid bits and the FSM)
//   bus    : btb_domain_tagged_if.slave (lookup / update / flush signals)
//
// Optional feature macro: BTB_DOMAIN_PARTITION_EN
//   When defined (requires DOM_W < IDX_W) the top DOM_W set bits are replaced
//   by the domain, giving every domain a private region; the flush then only
//   sweeps that region. When undefined the table is shared by all domains.
// -----------------------------------------------------------------------------
module btb_domain_tagged #(
    parameter int N_ENTRIES = 64,
    parameter int ADDR_W    = 32,
    parameter int TAG_W     = 12,
    parameter int DOM_W     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    btb_domain_tagged_if.slave   bus
);

    localparam int IDX_W = $clog2(N_ENTRIES);
`ifdef BTB_DOMAIN_PARTITION_EN
    localparam int PTR_W = IDX_W - DOM_W;
`else
    localparam int PTR_W = IDX_W;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Table storage: only the valid bits are reset.
    logic [N_ENTRIES-1:0] ent_valid_q;
    logic [DOM_W-1:0]     ent_dom_q  [N_ENTRIES];
    logic [TAG_W-1:0]     ent_tag_q  [N_ENTRIES];
    logic [ADDR_W-1:0]    ent_targ_q [N_ENTRIES];
    logic [1:0]           ent_ctr_q  [N_ENTRIES];

    // Flush engine
    state_e               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [DOM_W-1:0]     fdom_q, fdom_d;
    logic                 busy_s;
    logic                 done_s;

    // Lookup path
    logic [IDX_W-1:0]     lk_set_s;
    logic                 lk_blocked_s;
    logic                 lk_hit_s;
    logic                 valid_q;
    logic                 hit_q;
    logic [ADDR_W-1:0]    lk_targ_q;

    // Update path
    logic [IDX_W-1:0]     upd_set_s;
    logic [TAG_W-1:0]     upd_tag_s;
    logic                 upd_match_s;
    logic                 upd_blocked_s;
    logic                 upd_wr_s;
    logic [ADDR_W-1:0]    upd_targ_d;
    logic [1:0]           upd_ctr_d;

    // Sweep path
    logic [IDX_W-1:0]     sweep_set_s;
    logic                 sweep_inv_s;

    // Index bits outside set/tag are intentionally ignored.
    logic                 unused_s;
    assign unused_s = ^{bus.idx_i, bus.upd_idx_i};

`ifdef BTB_DOMAIN_PARTITION_EN
    assign lk_set_s    = {bus.domain_i, bus.idx_i[PTR_W-1:0]};
    assign upd_set_s   = {bus.upd_domain_i, bus.upd_idx_i[PTR_W-1:0]};
    assign sweep_set_s = {fdom_q, ptr_q};
`else
    assign lk_set_s    = bus.idx_i[IDX_W-1:0];
    assign upd_set_s   = bus.upd_idx_i[IDX_W-1:0];
    assign sweep_set_s = ptr_q;
`endif

    assign upd_tag_s = bus.upd_idx_i[IDX_W +: TAG_W];

    // Flush FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= {PTR_W{1'b0}};
            fdom_q  <= {DOM_W{1'b0}};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            fdom_q  <= fdom_d;
        end
    end

    // Flush FSM next-state logic; termination on the all-ones pointer
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        fdom_d  = fdom_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.flush_req_i) begin
                    state_d = ST_SWEEP;
                    ptr_d   = {PTR_W{1'b0}};
                    fdom_d  = bus.flush_domain_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                ptr_d = ptr_q + PTR_W'(1);
                if (ptr_q == {PTR_W{1'b1}}) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SWEEP;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Flush FSM outputs decoded from the state register
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_q)
            ST_SWEEP: busy_s = 1'b1;
            ST_DONE:  done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    assign bus.busy_o       = busy_s;
    assign bus.flush_done_o = done_s;

    // Sweep invalidates the pointed entry only when it belongs to the flushed domain
    assign sweep_inv_s = busy_s && ent_valid_q[sweep_set_s] &&
                         (ent_dom_q[sweep_set_s] == fdom_q);

    assign lk_blocked_s = busy_s && (bus.domain_i == fdom_q);

    // Lookup hit evaluation against pre-update table contents
    always_comb begin
        lk_hit_s = 1'b0;
        if (bus.lookup_en_i && !lk_blocked_s) begin
            lk_hit_s = ent_valid_q[lk_set_s] &&
                       (ent_dom_q[lk_set_s] == bus.domain_i) &&
                       (ent_tag_q[lk_set_s] == bus.idx_i[IDX_W +: TAG_W]) &&
                       (ent_ctr_q[lk_set_s] != 2'd0);
        end else begin
            lk_hit_s = 1'b0;
        end
    end

    // Registered lookup result
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            hit_q     <= 1'b0;
            lk_targ_q <= {ADDR_W{1'b0}};
        end else begin
            valid_q   <= bus.lookup_en_i;
            hit_q     <= lk_hit_s;
            lk_targ_q <= lk_hit_s ? ent_targ_q[lk_set_s] : {ADDR_W{1'b0}};
        end
    end

    assign bus.valid_o = valid_q;
    assign bus.hit_o   = hit_q;
    assign bus.targ_o  = lk_targ_q;

    assign upd_match_s = ent_valid_q[upd_set_s] &&
                         (ent_dom_q[upd_set_s] == bus.upd_domain_i) &&
                         (ent_tag_q[upd_set_s] == upd_tag_s);

    // Updates from the domain being flushed are dropped, and a same-set
    // sweep invalidate wins over any update.
    assign upd_blocked_s = (busy_s && (bus.upd_domain_i == fdom_q)) ||
                           (sweep_inv_s && (sweep_set_s == upd_set_s));

    // Update rules: counter hysteresis on match, allocation on taken miss
    always_comb begin
        upd_wr_s   = 1'b0;
        upd_targ_d = ent_targ_q[upd_set_s];
        upd_ctr_d  = ent_ctr_q[upd_set_s];
        if (!bus.update_en_i || upd_blocked_s) begin
            upd_wr_s = 1'b0;
        end else if (upd_match_s && bus.upd_taken_i) begin
            upd_wr_s = 1'b1;
            if (ent_targ_q[upd_set_s] == bus.upd_targ_i) begin
                upd_ctr_d = (ent_ctr_q[upd_set_s] == 2'd3) ? 2'd3 : ent_ctr_q[upd_set_s] + 2'd1;
            end else if (ent_ctr_q[upd_set_s] > 2'd1) begin
                upd_ctr_d = ent_ctr_q[upd_set_s] - 2'd1;
            end else begin
                upd_targ_d = bus.upd_targ_i;
                upd_ctr_d  = 2'd1;
            end
        end else if (upd_match_s) begin
            upd_wr_s  = 1'b1;
            upd_ctr_d = (ent_ctr_q[upd_set_s] == 2'd0) ? 2'd0 : ent_ctr_q[upd_set_s] - 2'd1;
        end else if (bus.upd_taken_i) begin
            upd_wr_s   = 1'b1;
            upd_targ_d = bus.upd_targ_i;
            upd_ctr_d  = 2'd1;
        end else begin
            upd_wr_s = 1'b0;
        end
    end

    // Valid bits: set by a written update, cleared by the sweep (sweep last wins)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ent_valid_q <= {N_ENTRIES{1'b0}};
        end else begin
            if (upd_wr_s) begin
                ent_valid_q[upd_set_s] <= 1'b1;
            end
            if (sweep_inv_s) begin
                ent_valid_q[sweep_set_s] <= 1'b0;
            end
        end
    end

    // Entry payload written by updates; not reset
    always_ff @(posedge clk_i) begin
        if (upd_wr_s) begin
            ent_dom_q[upd_set_s]  <= bus.upd_domain_i;
            ent_tag_q[upd_set_s]  <= upd_tag_s;
            ent_targ_q[upd_set_s] <= upd_targ_d;
            ent_ctr_q[upd_set_s]  <= upd_ctr_d;
        end
    end

endmodule

// File: tb/tb_btb_domain_tagged.sv
// -----------------------------------------------------------------------------
// tb_btb_domain_tagged
// Self-checking bench for btb_domain_tagged: directed scenarios followed by
// randomized traffic, all compared against a behavioural table model.
// -----------------------------------------------------------------------------
module tb_btb_domain_tagged;

    localparam int N_ENTRIES = 64;
    localparam int ADDR_W    = 32;
    localparam int TAG_W     = 12;
    localparam int DOM_W     = 2;
    localparam int IDX_W     = $clog2(N_ENTRIES);
    localparam int N_DOM     = 1 << DOM_W;
`ifdef BTB_DOMAIN_PARTITION_EN
    localparam bit PART = 1'b1;
`else
    localparam bit PART = 1'b0;
`endif
    localparam int REGION = PART ? (N_ENTRIES / N_DOM) : N_ENTRIES;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    btb_domain_tagged_if #(.ADDR_W(ADDR_W), .DOM_W(DOM_W)) bus ();

    btb_domain_tagged #(
        .N_ENTRIES(N_ENTRIES), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .DOM_W(DOM_W)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one entry per set, flush tracked as a progress count
    bit                m_valid [N_ENTRIES];
    logic [DOM_W-1:0]  m_dom   [N_ENTRIES];
    logic [TAG_W-1:0]  m_tag   [N_ENTRIES];
    logic [ADDR_W-1:0] m_targ  [N_ENTRIES];
    int                m_ctr   [N_ENTRIES];
    bit                m_busy;
    bit                m_done;
    logic [DOM_W-1:0]  m_fdom;
    int                m_k;

    task automatic check_eq(input string tag, input logic [ADDR_W-1:0] obs,
                            input logic [ADDR_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic int set_of(input logic [ADDR_W-1:0] a, input logic [DOM_W-1:0] d);
        return PART ? (int'(d) * REGION + (int'(a[IDX_W-1:0]) % REGION))
                    : int'(a[IDX_W-1:0]);
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return a[IDX_W +: TAG_W];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_ENTRIES; i++) m_valid[i] = 1'b0;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_k    = 0;
        m_fdom = '0;
    endtask

    task automatic model_update(input int s, input logic [ADDR_W-1:0] a,
                                input logic [DOM_W-1:0] d, input logic [ADDR_W-1:0] t,
                                input logic tk);
        bit match;
        match = m_valid[s] && (m_dom[s] == d) && (m_tag[s] == tag_of(a));
        if (match && tk) begin
            if (m_targ[s] == t)    m_ctr[s] = (m_ctr[s] >= 3) ? 3 : m_ctr[s] + 1;
            else if (m_ctr[s] > 1) m_ctr[s] = m_ctr[s] - 1;
            else begin
                m_targ[s] = t;
                m_ctr[s]  = 1;
            end
        end else if (match) begin
            m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
        end else if (tk) begin
            m_valid[s] = 1'b1;
            m_dom[s]   = d;
            m_tag[s]   = tag_of(a);
            m_targ[s]  = t;
            m_ctr[s]   = 1;
        end
    endtask

    task automatic idle_inputs();
        bus.lookup_en_i    = 1'b0;
        bus.idx_i          = '0;
        bus.domain_i       = '0;
        bus.update_en_i    = 1'b0;
        bus.upd_idx_i      = '0;
        bus.upd_domain_i   = '0;
        bus.upd_targ_i     = '0;
        bus.upd_taken_i    = 1'b0;
        bus.flush_req_i    = 1'b0;
        bus.flush_domain_i = '0;
    endtask

    // One clock: predict from pre-edge model state, advance model, compare outputs
    task automatic cycle();
        logic              ev, eh, sw_inv, blocked, new_done;
        logic [ADDR_W-1:0] et;
        int                ls, us, ss;
        ev = bus.lookup_en_i;
        ls = set_of(bus.idx_i, bus.domain_i);
        eh = ev && m_valid[ls] && (m_dom[ls] == bus.domain_i) &&
             (m_tag[ls] == tag_of(bus.idx_i)) && (m_ctr[ls] != 0) &&
             !(m_busy && (bus.domain_i == m_fdom));
        et = eh ? m_targ[ls] : '0;
        ss = m_busy ? (PART ? int'(m_fdom) * REGION + m_k : m_k) : 0;
        sw_inv = m_busy && m_valid[ss] && (m_dom[ss] == m_fdom);
        if (bus.update_en_i) begin
            us = set_of(bus.upd_idx_i, bus.upd_domain_i);
            blocked = (m_busy && (bus.upd_domain_i == m_fdom)) || (sw_inv && (ss == us));
            if (!blocked)
                model_update(us, bus.upd_idx_i, bus.upd_domain_i, bus.upd_targ_i, bus.upd_taken_i);
        end
        new_done = 1'b0;
        if (m_busy) begin
            if (sw_inv) m_valid[ss] = 1'b0;
            m_k++;
            if (m_k == REGION) begin
                m_busy   = 1'b0;
                new_done = 1'b1;
            end
        end else if (!m_done && bus.flush_req_i) begin
            m_busy = 1'b1;
            m_fdom = bus.flush_domain_i;
            m_k    = 0;
        end
        m_done = new_done;
        @(posedge clk);
        #1;
        check_eq("valid_o", bus.valid_o, ev);
        check_eq("hit_o", bus.hit_o, eh);
        check_eq("targ_o", bus.targ_o, et);
        check_eq("busy_o", bus.busy_o, m_busy);
        check_eq("flush_done_o", bus.flush_done_o, m_done);
    endtask

    task automatic do_lookup(input logic [ADDR_W-1:0] a, input logic [DOM_W-1:0] d);
        idle_inputs();
        bus.lookup_en_i = 1'b1;
        bus.idx_i       = a;
        bus.domain_i    = d;
        cycle();
    endtask

    task automatic do_update(input logic [ADDR_W-1:0] a, input logic [DOM_W-1:0] d,
                             input logic [ADDR_W-1:0] t, input logic tk);
        idle_inputs();
        bus.update_en_i  = 1'b1;
        bus.upd_idx_i    = a;
        bus.upd_domain_i = d;
        bus.upd_targ_i   = t;
        bus.upd_taken_i  = tk;
        cycle();
    endtask

    function automatic logic [ADDR_W-1:0] rand_idx();
        logic [ADDR_W-1:0] a;
        a = (ADDR_W'($urandom_range(0, 2)) << IDX_W) | ADDR_W'($urandom_range(0, 7)) |
            (ADDR_W'($urandom_range(0, 1)) << 30);
        return a;
    endfunction

    initial begin
        int busy_cnt;
        int done_at;
        int n;
        logic [ADDR_W-1:0] pool [3];
        pool[0] = 32'h0000_1000;
        pool[1] = 32'h0000_2000;
        pool[2] = 32'h0000_3000;

        // Reset state
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_valid", bus.valid_o, 1'b0);
        check_eq("rst_hit", bus.hit_o, 1'b0);
        check_eq("rst_targ", bus.targ_o, 32'h0);
        check_eq("rst_busy", bus.busy_o, 1'b0);
        check_eq("rst_done", bus.flush_done_o, 1'b0);
        rst = 1'b0;

        // Cold lookup misses
        do_lookup(32'h100, 2'd0);
        check_eq("cold_valid", bus.valid_o, 1'b1);
        check_eq("cold_hit", bus.hit_o, 1'b0);

        // Allocate in domain 1, visible only to domain 1
        do_update(32'h100, 2'd1, 32'hDEAD_0000, 1'b1);
        do_lookup(32'h100, 2'd1);
        check_eq("own_hit", bus.hit_o, 1'b1);
        check_eq("own_targ", bus.targ_o, 32'hDEAD_0000);
        do_lookup(32'h100, 2'd2);
        check_eq("xdom_hit", bus.hit_o, 1'b0);

        // Hysteresis: ctr 1 -> 3, then three differing taken updates
        do_update(32'h100, 2'd1, 32'hDEAD_0000, 1'b1);
        do_update(32'h100, 2'd1, 32'hDEAD_0000, 1'b1);
        do_update(32'h100, 2'd1, 32'h2000, 1'b1);
        do_lookup(32'h100, 2'd1);
        check_eq("hyst1_targ", bus.targ_o, 32'hDEAD_0000);
        do_update(32'h100, 2'd1, 32'h2000, 1'b1);
        do_lookup(32'h100, 2'd1);
        check_eq("hyst2_targ", bus.targ_o, 32'hDEAD_0000);
        do_update(32'h100, 2'd1, 32'h2000, 1'b1);
        do_lookup(32'h100, 2'd1);
        check_eq("hyst3_targ", bus.targ_o, 32'h2000);

        // Not-taken decrements to zero: entry stays but stops hitting
        do_update(32'h100, 2'd1, 32'h2000, 1'b0);
        do_lookup(32'h100, 2'd1);
        check_eq("ctr0_hit", bus.hit_o, 1'b0);

`ifdef BTB_DOMAIN_PARTITION_EN
        // Private regions: same index in two domains coexists
        do_update(32'h5, 2'd0, 32'hA0, 1'b1);
        do_update(32'h5, 2'd3, 32'hB0, 1'b1);
        do_lookup(32'h5, 2'd0);
        check_eq("part_d0", bus.targ_o, 32'hA0);
        do_lookup(32'h5, 2'd3);
        check_eq("part_d3", bus.targ_o, 32'hB0);
`endif

        // Fill sets 0..3 in domain 1 and 4..7 in domain 2, then flush domain 1
        for (int s = 0; s < 4; s++) do_update(ADDR_W'(s), 2'd1, 32'h1000 + ADDR_W'(s), 1'b1);
        for (int s = 4; s < 8; s++) do_update(ADDR_W'(s), 2'd2, 32'h1000 + ADDR_W'(s), 1'b1);
        idle_inputs();
        bus.flush_req_i    = 1'b1;
        bus.flush_domain_i = 2'd1;
        cycle();
        idle_inputs();
        busy_cnt = 0;
        done_at  = 0;
        n        = 1;
        while (n <= 4 * REGION && done_at == 0) begin
            if (bus.busy_o) busy_cnt++;
            if (bus.flush_done_o) done_at = n;
            bus.flush_req_i    = (n == 5);
            bus.flush_domain_i = 2'd2;
            cycle();
            n++;
        end
        idle_inputs();
        check_eq("busy_cycles", busy_cnt, REGION);
        check_eq("done_cycle", done_at, REGION + 1);
        repeat (3) cycle();
        for (int s = 0; s < 4; s++) begin
            do_lookup(ADDR_W'(s), 2'd1);
            check_eq("flushed_miss", bus.hit_o, 1'b0);
        end
        for (int s = 4; s < 8; s++) begin
            do_lookup(ADDR_W'(s), 2'd2);
            check_eq("kept_hit", bus.hit_o, 1'b1);
        end

        // Randomized traffic including flushes
        for (int i = 0; i < 2500; i++) begin
            idle_inputs();
            bus.lookup_en_i    = ($urandom_range(0, 3) != 0);
            bus.idx_i          = rand_idx();
            bus.domain_i       = DOM_W'($urandom_range(0, N_DOM - 1));
            bus.update_en_i    = ($urandom_range(0, 1) != 0);
            bus.upd_idx_i      = rand_idx();
            bus.upd_domain_i   = DOM_W'($urandom_range(0, N_DOM - 1));
            bus.upd_targ_i     = pool[$urandom_range(0, 2)];
            bus.upd_taken_i    = ($urandom_range(0, 3) != 0);
            bus.flush_req_i    = ($urandom_range(0, 99) == 0);
            bus.flush_domain_i = DOM_W'($urandom_range(0, N_DOM - 1));
            cycle();
        end

        // Reset in the middle of a sweep
        idle_inputs();
        n = 0;
        while ((m_busy || m_done) && n < 4 * REGION) begin
            cycle();
            n++;
        end
        bus.flush_req_i    = 1'b1;
        bus.flush_domain_i = 2'd0;
        cycle();
        idle_inputs();
        repeat (9) cycle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_busy", bus.busy_o, 1'b0);
        check_eq("midrst_done", bus.flush_done_o, 1'b0);
        check_eq("midrst_valid", bus.valid_o, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (REGION + 4) cycle();
        for (int d = 0; d < N_DOM; d++) begin
            for (int s = 0; s < 8; s++) begin
                do_lookup(ADDR_W'(s), DOM_W'(d));
                check_eq("postrst_miss", bus.hit_o, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btb_domain_tagged.md
Name: btb_domain_tagged

Overview:
- Parametrised, domain-tagged branch target buffer that sits beside the TAGE direction predictor under the top-level miter harness.
- Supplies a predicted target for a lookup index. Every entry is tagged with the security domain that allocated it.
- A lookup from one domain never hits an entry owned by another domain.
- A sequential per-domain flush engine clears one domain's entries on a context switch. This is the block the noninterference checks target.

Parameters:
- N_ENTRIES, 64, number of table entries; power of two, 4..1024
- ADDR_W, 32, width of lookup/update index and target
- TAG_W, 12, tag bits taken from idx[IDX_W +: TAG_W], where IDX_W = log2(N_ENTRIES); IDX_W + TAG_W <= ADDR_W
- DOM_W, 2, width of domain identifier; N_DOMAINS = 2**DOM_W

Ports:
- clk_i, input, 1, clock
- rst_i, input, 1, reset, asynchronous, active-high
- lookup_en_i, input, 1, lookup request this cycle
- idx_i, input, ADDR_W, lookup index
- domain_i, input, DOM_W, domain of lookup
- valid_o, input→output, 1, registered lookup result valid (output)
- hit_o, output, 1, lookup hit
- targ_o, output, ADDR_W, predicted target; 0 when no hit
- update_en_i, input, 1, commit-time update
- upd_idx_i, input, ADDR_W, update index
- upd_domain_i, input, DOM_W, domain of update
- upd_targ_i, input, ADDR_W, resolved target
- upd_taken_i, input, 1, branch resolved taken
- flush_req_i, input, 1, start domain flush (pulse)
- flush_domain_i, input, DOM_W, domain to flush
- busy_o, output, 1, flush in progress
- flush_done_o, output, 1, one-cycle pulse when flush completes

Behaviour:
- Entry fields: valid, dom[DOM_W], tag[TAG_W], targ[ADDR_W], ctr[2].
- Entry set: set = idx[IDX_W-1:0].
- Reset: all valid bits = 0. valid_o = 0, hit_o = 0, targ_o = 0, busy_o = 0, flush_done_o = 0. FSM = IDLE. Only the valid bits need reset; the other entry fields may be left unreset.
- Lookup latency is 1 cycle. Lookup presented at cycle t produces outputs at t+1:
  - valid_o = lookup_en_i at t.
  - hit_o = valid & dom==domain_i & tag==idx tag & ctr!=0.
  - targ_o = hit ? targ : 0.
  - valid_o = 0 ⇒ hit_o = 0 and targ_o = 0.
- Update takes effect at the next clock edge. Entries are matched on dom, tag and valid.
  - Match & taken & targ==upd_targ: ctr saturates-increment (max 3).
  - Match & taken & targ!=upd_targ:
    - ctr>1: ctr-1.
    - ctr<=1: replace targ, ctr = 1.
  - Match & !taken: ctr saturates-decrement (min 0). An entry with ctr 0 stays valid but never hits.
  - No match & taken: allocate/overwrite the set. valid = 1, dom/tag from the update, targ = upd_targ, ctr = 1.
  - No match & !taken: no change.
- Same set updated and looked up in the same cycle: the lookup sees the pre-update contents (read-before-write).
- Flush FSM, IDLE → SWEEP → DONE → IDLE:
  - IDLE: flush_req_i latches flush_domain_i, clears the sweep pointer to 0, and moves to SWEEP.
  - SWEEP: busy_o = 1. Each cycle, entry[ptr] is invalidated if its dom matches the latched domain. ptr increments. After ptr = N_ENTRIES-1 the FSM moves to DONE.
  - DONE: flush_done_o = 1 for one cycle, busy_o = 0, then back to IDLE.
  - Total: busy_o is high for exactly N_ENTRIES cycles. flush_done_o fires N_ENTRIES+1 cycles after the request edge.
- While busy_o = 1:
  - flush_req_i is ignored.
  - Lookups in the flushed domain return hit_o = 0.
  - Updates from the flushed domain are dropped.
  - Lookups and updates from other domains proceed normally. A same-cycle sweep invalidate takes priority over an update to the same set.
- Reset asserted mid-flush: FSM returns to IDLE immediately, all entries invalid, no flush_done_o pulse.
- Pointer width is IDX_W. Termination is detected on the all-ones pointer, so no wrap-around overrun occurs.

Optional Feature:
- Macro: BTB_DOMAIN_PARTITION_EN.
- When defined, requires DOM_W < IDX_W. The top DOM_W set bits are replaced by the domain, for both lookup and update. Each domain owns a private N_ENTRIES/N_DOMAINS region, so there is no cross-domain eviction or timing channel.
- Flush then sweeps only that region: busy_o is high for N_ENTRIES/N_DOMAINS cycles, and ptr runs over the low IDX_W-DOM_W bits.
- When undefined, the table is shared across domains and isolation relies on the dom tag compare only.

Test Plan:
- Reset, then lookup idx=0x100 in domain 0 → valid_o=1, hit_o=0, targ_o=0 one cycle later.
- Taken update idx=0x100, dom 1, targ=0xDEAD0000; lookup same idx in dom 1 → hit_o=1, targ_o=0xDEAD0000. Same lookup in dom 2 → hit_o=0.
- Hysteresis: entry ctr=3, taken update with targ=0x2000 (differs) → ctr=2, target unchanged; repeat → ctr=1; repeat → targ=0x2000, ctr=1.
- Fill sets 0..3 in dom 1 and sets 4..7 in dom 2 (N_ENTRIES=64); flush_req dom 1 → busy_o high 64 cycles, flush_done_o at cycle 65. Dom 1 lookups then miss, dom 2 lookups still hit. A second flush_req during busy has no effect.
- Assert rst_i at sweep cycle 10 → busy_o=0 immediately, no flush_done_o, every lookup misses afterwards.
- With BTB_DOMAIN_PARTITION_EN: dom 0 and dom 3 updates to idx=0x5 both survive (different regions); flush dom 0 → busy_o high 16 cycles.
